// File: rtl/link_table_client.sv
// Link-table client: turns upstream commands into manager orders and
// returns one response per command, with timeout and stale-result draining.
module link_table_client #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_type,
  input  logic [TABLE_WIDTH-1:0] cmd_table,
  input  logic [ADDR_WIDTH-1:0]  cmd_node,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  output logic                   order_valid,
  input  logic                   order_busy,
  output logic [1:0]             order_type,
  output logic [TABLE_WIDTH-1:0] order_table,
  output logic [ADDR_WIDTH-1:0]  order_node,
  output logic [DATA_WIDTH-1:0]  order_data,
  input  logic                   dout_valid,
  output logic                   dout_busy,
  input  logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_type,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_ok,
  output logic                   rsp_timeout,
  output logic [15:0]            cnt_done,
  output logic [15:0]            cnt_fail,
  output logic [15:0]            cnt_timeout,
  output logic [15:0]            cnt_stale
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [1:0]  T_READ   = 2'b11;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [15:0] wait_cnt;
  logic        drop_pending;

  logic accept, issue, got, tmo, rexit, stale;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign dout_busy = !((state == WAIT) ||
                       drop_pending);
  assign stale     = (state != WAIT) &&
                     drop_pending && dout_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    got     = 1'b0;
    tmo     = 1'b0;
    rexit   = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (!order_busy) begin
        issue   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // a result arriving on the last wait cycle beats the timeout
        if (dout_valid) begin
          got     = 1'b1;
          state_d = RESP;
        end else if (wait_cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        rexit   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_valid  <= 1'b0;
      order_type   <= '0;
      order_table  <= '0;
      order_node   <= '0;
      order_data   <= '0;
      wait_cnt     <= '0;
      drop_pending <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_type     <= '0;
      rsp_data     <= '0;
      rsp_ok       <= 1'b0;
      rsp_timeout  <= 1'b0;
      cnt_done     <= '0;
      cnt_fail     <= '0;
      cnt_timeout  <= '0;
      cnt_stale    <= '0;
    end else begin
      if (accept) begin
        order_valid <= 1'b1;
        order_type  <= cmd_type;
        order_table <= cmd_table;
        order_node  <= cmd_node;
        order_data  <= cmd_data;
      end
      if (issue) order_valid <= 1'b0;

      if (issue)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 16'd1;

      if (got) begin
        rsp_valid   <= 1'b1;
        rsp_type    <= order_type;
        rsp_data    <= dout_data;
        rsp_ok      <= (order_type == T_READ) ||
                       (|dout_data);
        rsp_timeout <= 1'b0;
      end
      if (tmo) begin
        rsp_valid    <= 1'b1;
        rsp_type     <= order_type;
        rsp_data     <= '0;
        rsp_ok       <= 1'b0;
        rsp_timeout  <= 1'b1;
        drop_pending <= 1'b1;
        cnt_timeout  <= sat_inc(cnt_timeout);
      end

      if (rexit) begin
        rsp_valid <= 1'b0;
        if (!rsp_timeout)
          cnt_done <= sat_inc(cnt_done);
        if (!rsp_timeout && !rsp_ok)
          cnt_fail <= sat_inc(cnt_fail);
      end

      // late result of a timed-out order is swallowed here
      if (stale) begin
        drop_pending <= 1'b0;
        cnt_stale    <= sat_inc(cnt_stale);
      end
    end
  end

endmodule
